// File: rtl/aiken_down_counter_if.sv
// Digit-bus bundle for the 2421 down counter: preset/decrement strobes in, count views and flags out.
interface aiken_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_code;
  logic                  en;
  logic [4*DIGITS-1:0]   bcd;
  logic [4*DIGITS-1:0]   aiken;
  logic                  zero;
  logic                  borrow;
  logic                  load_err;

  // Handshake: no ready/back-pressure. load and en are strobes sampled on every
  // rising clk edge (load wins); borrow/load_err are one-cycle registered pulses.
  modport master (
    output load, load_code, en,
    input  bcd, aiken, zero, borrow, load_err
  );

  modport slave (
    input  load, load_code, en,
    output bcd, aiken, zero, borrow, load_err
  );
endinterface

// File: rtl/aiken_down_counter.sv
// Multi-digit BCD down counter preset from a 2421 (Aiken) digit bus, with 2421 re-encode,
// illegal-code rejection and underflow flag.
module aiken_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  aiken_down_counter_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] count;
  logic         borrow_q;
  logic         load_err_q;
  logic [W-1:0] load_bcd;
  logic         load_ok;
  logic [W-1:0] dec_count;
  logic [W-1:0] enc_count;
  logic         chain;

  function automatic logic code_legal(input logic [3:0] c);
    return (c <= 4'd4) || (c >= 4'd11);
  endfunction

  function automatic logic [3:0] decode_2421(input logic [3:0] c);
    return (c >= 4'd11) ? c - 4'd6 : c;
  endfunction

  function automatic logic [3:0] encode_2421(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd6 : d;
  endfunction

  always_comb begin
    load_bcd = '0;
    load_ok  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_bcd[4*i +: 4] = decode_2421(bus.load_code[4*i +: 4]);
      if (!code_legal(bus.load_code[4*i +: 4])) load_ok = 1'b0;
    end
  end

  // Ripple borrow from digit 0 upward; at count 0 this naturally yields all 9s.
  always_comb begin
    dec_count = count;
    chain     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (chain) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_count[4*i +: 4] = 4'd9;
        end else begin
          dec_count[4*i +: 4] = count[4*i +: 4] - 4'd1;
          chain = 1'b0;
        end
      end
    end
  end

  always_comb begin
    enc_count = '0;
    for (int i = 0; i < DIGITS; i++) enc_count[4*i +: 4] = encode_2421(count[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      borrow_q   <= 1'b0;
      load_err_q <= !load_ok;
      if (load_ok) count <= load_bcd;
    end else if (bus.en) begin
      load_err_q <= 1'b0;
      if (count == '0) begin
        borrow_q <= 1'b1;
        if (WRAP) count <= dec_count;
      end else begin
        borrow_q <= 1'b0;
        count    <= dec_count;
      end
    end else begin
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end
  end

  assign bus.bcd      = count;
  assign bus.aiken    = enc_count;
  assign bus.zero     = (count == '0);
  assign bus.borrow   = borrow_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_aiken_down_counter.sv
// Directed bench for aiken_down_counter: a WRAP=1 and a WRAP=0 instance driven in lockstep.
module tb_aiken_down_counter;
  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_code;
  logic       en;
  int         total;
  int         bad;

  aiken_down_counter_if #(.DIGITS(2)) b1 ();
  aiken_down_counter_if #(.DIGITS(2)) b0 ();

  assign b1.load = load;
  assign b1.load_code = load_code;
  assign b1.en = en;
  assign b0.load = load;
  assign b0.load_code = load_code;
  assign b0.en = en;

  aiken_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_wrap (.clk(clk), .reset(reset), .bus(b1));
  aiken_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_hold (.clk(clk), .reset(reset), .bus(b0));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] code);
    load = 1'b1; load_code = code; en = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; en = 1'b0; load_code = 8'h00;
    #2;
    total++; if (b1.bcd !== 8'h00) begin bad++; $display("FAIL reset_bcd got=%h exp=00", b1.bcd); end
    total++; if (b1.aiken !== 8'h00) begin bad++; $display("FAIL reset_aiken got=%h exp=00", b1.aiken); end
    total++; if (b1.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", b1.zero); end
    total++; if (b1.borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", b1.borrow); end
    total++; if (b1.load_err !== 1'b0) begin bad++; $display("FAIL reset_load_err got=%b exp=0", b1.load_err); end
    total++; if (b0.bcd !== 8'h00) begin bad++; $display("FAIL reset_hold_bcd got=%h exp=00", b0.bcd); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_legal_load();
    do_load(8'hBF);
    total++; if (b1.bcd !== 8'h59) begin bad++; $display("FAIL load_bcd got=%h exp=59", b1.bcd); end
    total++; if (b1.aiken !== 8'hBF) begin bad++; $display("FAIL load_aiken got=%h exp=BF", b1.aiken); end
    total++; if (b1.zero !== 1'b0) begin bad++; $display("FAIL load_zero got=%b exp=0", b1.zero); end
    total++; if (b1.load_err !== 1'b0) begin bad++; $display("FAIL load_err_clear got=%b exp=0", b1.load_err); end
  endtask

  task automatic test_digit_borrow();
    do_load(8'h10);
    en = 1'b1;
    step();
    total++; if (b1.bcd !== 8'h09) begin bad++; $display("FAIL borrow1_bcd got=%h exp=09", b1.bcd); end
    total++; if (b1.aiken !== 8'h0F) begin bad++; $display("FAIL borrow1_aiken got=%h exp=0F", b1.aiken); end
    step();
    total++; if (b1.bcd !== 8'h08) begin bad++; $display("FAIL borrow2_bcd got=%h exp=08", b1.bcd); end
    total++; if (b1.aiken !== 8'h0E) begin bad++; $display("FAIL borrow2_aiken got=%h exp=0E", b1.aiken); end
    total++; if (b1.borrow !== 1'b0) begin bad++; $display("FAIL borrow2_flag got=%b exp=0", b1.borrow); end
    en = 1'b0;
  endtask

  task automatic test_underflow();
    do_load(8'h01);
    en = 1'b1;
    step();
    total++; if (b1.bcd !== 8'h00) begin bad++; $display("FAIL uf1_bcd got=%h exp=00", b1.bcd); end
    total++; if (b1.zero !== 1'b1) begin bad++; $display("FAIL uf1_zero got=%b exp=1", b1.zero); end
    total++; if (b1.borrow !== 1'b0) begin bad++; $display("FAIL uf1_borrow got=%b exp=0", b1.borrow); end
    step();
    en = 1'b0;
    total++; if (b1.bcd !== 8'h99) begin bad++; $display("FAIL uf2_bcd got=%h exp=99", b1.bcd); end
    total++; if (b1.aiken !== 8'hFF) begin bad++; $display("FAIL uf2_aiken got=%h exp=FF", b1.aiken); end
    total++; if (b1.borrow !== 1'b1) begin bad++; $display("FAIL uf2_borrow got=%b exp=1", b1.borrow); end
    total++; if (b0.bcd !== 8'h00) begin bad++; $display("FAIL uf2_hold_bcd got=%h exp=00", b0.bcd); end
    total++; if (b0.borrow !== 1'b1) begin bad++; $display("FAIL uf2_hold_borrow got=%b exp=1", b0.borrow); end
    step();
    total++; if (b1.borrow !== 1'b0) begin bad++; $display("FAIL uf3_borrow_pulse got=%b exp=0", b1.borrow); end
    total++; if (b1.bcd !== 8'h99) begin bad++; $display("FAIL uf3_hold_bcd got=%h exp=99", b1.bcd); end
  endtask

  task automatic test_illegal_load();
    do_load(8'h33);
    total++; if (b1.bcd !== 8'h33) begin bad++; $display("FAIL il_preset_bcd got=%h exp=33", b1.bcd); end
    do_load(8'h47);
    total++; if (b1.bcd !== 8'h33) begin bad++; $display("FAIL il_bcd_kept got=%h exp=33", b1.bcd); end
    total++; if (b1.load_err !== 1'b1) begin bad++; $display("FAIL il_load_err got=%b exp=1", b1.load_err); end
    load = 1'b1; en = 1'b1; load_code = 8'h21;
    step();
    load = 1'b0; en = 1'b0;
    total++; if (b1.bcd !== 8'h21) begin bad++; $display("FAIL il_reload_bcd got=%h exp=21", b1.bcd); end
    total++; if (b1.load_err !== 1'b0) begin bad++; $display("FAIL il_err_pulse got=%b exp=0", b1.load_err); end
    do_load(8'h5A);
    total++; if (b1.load_err !== 1'b1) begin bad++; $display("FAIL il_digit1_err got=%b exp=1", b1.load_err); end
    total++; if (b1.bcd !== 8'h21) begin bad++; $display("FAIL il_digit1_bcd got=%h exp=21", b1.bcd); end
  endtask

  task automatic test_mid_reset();
    do_load(8'h4B);
    total++; if (b1.bcd !== 8'h45) begin bad++; $display("FAIL mr_load_bcd got=%h exp=45", b1.bcd); end
    en = 1'b1;
    step();
    total++; if (b1.bcd !== 8'h44) begin bad++; $display("FAIL mr_dec_bcd got=%h exp=44", b1.bcd); end
    #2 reset = 1'b0;
    #1;
    total++; if (b1.bcd !== 8'h00) begin bad++; $display("FAIL mr_async_bcd got=%h exp=00", b1.bcd); end
    total++; if (b1.aiken !== 8'h00) begin bad++; $display("FAIL mr_async_aiken got=%h exp=00", b1.aiken); end
    total++; if (b1.zero !== 1'b1) begin bad++; $display("FAIL mr_async_zero got=%b exp=1", b1.zero); end
    reset = 1'b1;
    step();
    en = 1'b0;
    total++; if (b1.bcd !== 8'h99) begin bad++; $display("FAIL mr_wrap_bcd got=%h exp=99", b1.bcd); end
    total++; if (b1.borrow !== 1'b1) begin bad++; $display("FAIL mr_wrap_borrow got=%b exp=1", b1.borrow); end
  endtask

  task automatic test_back_to_back();
    do_load(8'h02);
    en = 1'b1;
    step();
    total++; if (b1.bcd !== 8'h01) begin bad++; $display("FAIL bb1_bcd got=%h exp=01", b1.bcd); end
    step();
    total++; if (b1.bcd !== 8'h00) begin bad++; $display("FAIL bb2_bcd got=%h exp=00", b1.bcd); end
    step();
    total++; if (b1.borrow !== 1'b1) begin bad++; $display("FAIL bb3_borrow got=%b exp=1", b1.borrow); end
    total++; if (b0.borrow !== 1'b1) begin bad++; $display("FAIL bb3_hold_borrow got=%b exp=1", b0.borrow); end
    step();
    total++; if (b0.borrow !== 1'b1) begin bad++; $display("FAIL bb4_hold_borrow_rpt got=%b exp=1", b0.borrow); end
    total++; if (b1.bcd !== 8'h98) begin bad++; $display("FAIL bb4_bcd got=%h exp=98", b1.bcd); end
    total++; if (b1.aiken !== 8'hFE) begin bad++; $display("FAIL bb4_aiken got=%h exp=FE", b1.aiken); end
    total++; if (b1.borrow !== 1'b0) begin bad++; $display("FAIL bb4_borrow got=%b exp=0", b1.borrow); end
    en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_legal_load();
    test_digit_borrow();
    test_underflow();
    test_illegal_load();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
